// File: rtl/traffic_pkg.sv
// Shared light codes, monitor state and fault-cause encodings for the intersection.
// Latency: none, types and pure functions only.
// Backpressure: not applicable.
package traffic_pkg;

  localparam logic [2:0] LIGHT_OFF   = 3'b000;
  localparam logic [2:0] LIGHT_GREEN = 3'b001;
  localparam logic [2:0] LIGHT_AMBER = 3'b010;
  localparam logic [2:0] LIGHT_RED   = 3'b100;

  typedef enum logic [1:0] {
    ST_NORMAL  = 2'b00,
    ST_SUSPECT = 2'b01,
    ST_FLASH   = 2'b10,
    ST_ALLRED  = 2'b11
  } mon_state_t;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_CONFLICT = 2'b01,
    FC_ILLEGAL  = 2'b10,
    FC_STUCK    = 2'b11
  } fault_code_t;

  // One light code per approach: main 1, main turn, main 2, side street.
  typedef struct packed {
    logic [2:0] m1;
    logic [2:0] mt;
    logic [2:0] m2;
    logic [2:0] s;
  } lamps_t;

  localparam lamps_t LAMPS_ALL_RED = '{m1: LIGHT_RED, mt: LIGHT_RED, m2: LIGHT_RED, s: LIGHT_RED};

  function automatic logic is_one_hot(input logic [2:0] code);
    return (code == LIGHT_GREEN) || (code == LIGHT_AMBER) || (code == LIGHT_RED);
  endfunction

  // Side street against any main approach, or turn lane against main 2.
  function automatic logic has_conflict(input lamps_t l);
    return ((l.s != LIGHT_RED) && ((l.m1 != LIGHT_RED) || (l.mt != LIGHT_RED) || (l.m2 != LIGHT_RED)))
        || ((l.mt != LIGHT_RED) && (l.m2 != LIGHT_RED));
  endfunction

  // Fail-safe display: mains flash amber, side street flashes red.
  function automatic lamps_t flash_lamps(input logic lit);
    lamps_t l;
    l.m1 = lit ? LIGHT_AMBER : LIGHT_OFF;
    l.mt = lit ? LIGHT_AMBER : LIGHT_OFF;
    l.m2 = lit ? LIGHT_AMBER : LIGHT_OFF;
    l.s  = lit ? LIGHT_RED   : LIGHT_OFF;
    return l;
  endfunction

endpackage

// File: rtl/lamp_flasher.sv
// Half-period counter and phase toggle driving the fail-safe flash pattern.
// Latency: lit_next is the phase the lamp register should present in the following cycle.
// Backpressure: none; counts every cycle while en is high, parks lit with counter 0 otherwise.
module lamp_flasher #(
  parameter int HALF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic lit_next
);

  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             lit_q;
  logic             wrap;

  assign wrap     = (cnt_q == CNT_LAST);
  assign lit_next = en ? (wrap ? ~lit_q : lit_q) : 1'b1;

  // Count cycles within a half period and flip the phase at each boundary.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_q <= '0;
      lit_q <= 1'b1;
    end else if (wrap) begin
      cnt_q <= '0;
      lit_q <= ~lit_q;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_lamp_monitor.sv
// Conflict/illegal/stuck monitor between phase controller and lamp drivers, with fail-safe flash.
// Latency: lamps and status are registered, one cycle after the inputs they respond to.
// Backpressure: none; inputs are sampled every cycle.
module traffic_lamp_monitor
  import traffic_pkg::*;
#(
  parameter int MAX_HOLD   = 12,
  parameter int FLASH_HALF = 4,
  parameter int ALLRED_CYC = 3,
  parameter int CLEAN_CYC  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] in_M1,
  input  logic [2:0] in_MT,
  input  logic [2:0] in_M2,
  input  logic [2:0] in_S,
  input  logic       fault_clr,
  output logic [2:0] lamp_M1,
  output logic [2:0] lamp_MT,
  output logic [2:0] lamp_M2,
  output logic [2:0] lamp_S,
  output logic       fault,
  output logic [1:0] fault_code,
  output logic [1:0] mon_state
);

  localparam int HOLD_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int CLEAN_W  = (CLEAN_CYC > 0) ? $clog2(CLEAN_CYC + 1) : 1;
  localparam int ALLRED_W = (ALLRED_CYC > 1) ? $clog2(ALLRED_CYC) : 1;

  localparam logic [HOLD_W-1:0]   HOLD_SAT    = HOLD_W'(MAX_HOLD);
  localparam logic [CLEAN_W-1:0]  CLEAN_SAT   = CLEAN_W'(CLEAN_CYC);
  localparam logic [ALLRED_W-1:0] ALLRED_LAST = ALLRED_W'(ALLRED_CYC - 1);

  lamps_t               in_l;
  lamps_t               prev_q;
  logic                 seen_q;
  logic [HOLD_W-1:0]    hold_q;
  logic [HOLD_W-1:0]    hold_now;
  logic [CLEAN_W-1:0]   clean_q;
  logic [CLEAN_W-1:0]   clean_now;
  logic                 conflict_now;
  logic                 illegal_now;
  logic                 stuck_now;
  logic                 raw_fault;
  fault_code_t          raw_code;

  mon_state_t           state_q;
  fault_code_t          code_q;
  lamps_t               lamp_q;
  logic                 fault_q;
  logic [ALLRED_W-1:0]  allred_q;
  logic                 flash_en;
  logic                 flash_lit;

  assign in_l = {in_M1, in_MT, in_M2, in_S};

  // Classify the current inputs; hold_now counts cycles the vector has repeated,
  // so a value present for MAX_HOLD+1 cycles in a row is flagged stuck.
  always_comb begin
    conflict_now = has_conflict(in_l);
    illegal_now  = !(is_one_hot(in_l.m1) && is_one_hot(in_l.mt)
                     && is_one_hot(in_l.m2) && is_one_hot(in_l.s));
    hold_now = '0;
    if (seen_q && (in_l == prev_q)) begin
      hold_now = (hold_q == HOLD_SAT) ? hold_q : hold_q + HOLD_W'(1);
    end
    stuck_now = (hold_now >= HOLD_SAT);
    raw_fault = conflict_now || illegal_now || stuck_now;
    raw_code  = FC_NONE;
    if (conflict_now) begin
      raw_code = FC_CONFLICT;
    end else if (illegal_now) begin
      raw_code = FC_ILLEGAL;
    end else if (stuck_now) begin
      raw_code = FC_STUCK;
    end
    clean_now = '0;
    if (!raw_fault) begin
      clean_now = (clean_q == CLEAN_SAT) ? clean_q : clean_q + CLEAN_W'(1);
    end
  end

  // Remember the last input vector plus the repeat and fault-free run lengths.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q  <= '0;
      seen_q  <= 1'b0;
      hold_q  <= '0;
      clean_q <= '0;
    end else begin
      prev_q  <= in_l;
      seen_q  <= 1'b1;
      hold_q  <= hold_now;
      clean_q <= clean_now;
    end
  end

  assign flash_en = (state_q == ST_FLASH);

  lamp_flasher #(
    .HALF(FLASH_HALF)
  ) u_flasher (
    .clk      (clk),
    .rst      (rst),
    .en       (flash_en),
    .lit_next (flash_lit)
  );

  // Monitor FSM; lamps are loaded with the pattern of the state being entered,
  // so faulty inputs never reach the lamps and fault rises from the first flash cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_NORMAL;
      code_q   <= FC_NONE;
      lamp_q   <= LAMPS_ALL_RED;
      fault_q  <= 1'b0;
      allred_q <= '0;
    end else begin
      case (state_q)
        ST_NORMAL: begin
          if (raw_fault) begin
            state_q <= ST_SUSPECT;
            lamp_q  <= LAMPS_ALL_RED;
          end else begin
            lamp_q  <= in_l;
          end
        end
        ST_SUSPECT: begin
          if (raw_fault) begin
            state_q <= ST_FLASH;
            code_q  <= raw_code;
            fault_q <= 1'b1;
            lamp_q  <= flash_lamps(1'b1);
          end else begin
            state_q <= ST_NORMAL;
            lamp_q  <= in_l;
          end
        end
        ST_FLASH: begin
          if (fault_clr && (clean_now >= CLEAN_SAT)) begin
            state_q  <= ST_ALLRED;
            allred_q <= '0;
            lamp_q   <= LAMPS_ALL_RED;
          end else begin
            lamp_q   <= flash_lamps(flash_lit);
          end
        end
        ST_ALLRED: begin
          if (raw_fault) begin
            state_q <= ST_FLASH;
            code_q  <= raw_code;
            lamp_q  <= flash_lamps(1'b1);
          end else if (allred_q == ALLRED_LAST) begin
            state_q <= ST_NORMAL;
            code_q  <= FC_NONE;
            fault_q <= 1'b0;
            lamp_q  <= in_l;
          end else begin
            allred_q <= allred_q + ALLRED_W'(1);
            lamp_q   <= LAMPS_ALL_RED;
          end
        end
        default: begin
          state_q <= ST_NORMAL;
          lamp_q  <= LAMPS_ALL_RED;
        end
      endcase
    end
  end

  assign lamp_M1    = lamp_q.m1;
  assign lamp_MT    = lamp_q.mt;
  assign lamp_M2    = lamp_q.m2;
  assign lamp_S     = lamp_q.s;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign mon_state  = state_q;

endmodule

// File: doc/traffic_lamp_monitor.md
TRAFFIC_LAMP_MONITOR -- requirements
Module: traffic_lamp_monitor

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 12: maximum cycles light inputs may stay unchanged before a stuck fault.
REQ-002 SHALL have parameter FLASH_HALF, default 4: cycles per half-period of fail-safe flashing.
REQ-003 SHALL have parameter ALLRED_CYC, default 3: cycles of all-red when returning to normal.
REQ-004 SHALL have parameter CLEAN_CYC, default 8: consecutive fault-free input cycles required before recovery.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-007 SHALL have ports in_M1, in_MT, in_M2, in_S  input  3 each  light codes from the phase controller (bit0 green, bit1 amber, bit2 red).
REQ-008 SHALL have port fault_clr  input  1  operator request to leave fail-safe mode.
REQ-009 SHALL have ports lamp_M1, lamp_MT, lamp_M2, lamp_S  output  3 each  registered lamp drive, same encoding.
REQ-010 SHALL have port fault  output  1  high in SUSPECT-confirmed, FLASH and ALLRED states.
REQ-011 SHALL have port fault_code  output  2  sticky cause: 00 none, 01 conflict, 10 illegal code, 11 stuck.
REQ-012 SHALL have port mon_state  output  2  current state: 00 NORMAL, 01 SUSPECT, 10 FLASH, 11 ALLRED.

Function
REQ-013 Illegal SHALL mean any input code not exactly one-hot.
REQ-014 Conflict SHALL mean (in_S not red AND any main input not red) OR (in_MT not red AND in_M2 not red).
REQ-015 Stuck SHALL mean the 12-bit concatenated input vector unchanged for more than MAX_HOLD consecutive cycles; hold counter saturates, clears on any change.
REQ-016 Raw fault priority SHALL be conflict > illegal > stuck when simultaneous.
REQ-017 NORMAL: lamps SHALL equal inputs with 1-cycle latency; raw fault -> SUSPECT.
REQ-018 SUSPECT: lamps SHALL be all red (100); raw fault present this cycle -> FLASH, latch fault_code; raw fault absent -> NORMAL, fault_code stays 00.
REQ-019 FLASH: main lamps SHALL toggle amber/off (010/000), lamp_S SHALL toggle red/off (100/000), starting lit, toggling every FLASH_HALF cycles.
REQ-020 FLASH -> ALLRED SHALL occur only when fault_clr is high AND clean counter has reached CLEAN_CYC; clean counter resets on any raw fault.
REQ-021 ALLRED: all lamps 100 for ALLRED_CYC cycles, then NORMAL and fault_code cleared to 00; raw fault during ALLRED -> FLASH with new code.
REQ-022 fault_clr outside FLASH SHALL be ignored; fault_code SHALL not change in FLASH except on ALLRED exit.
REQ-023 Lamp outputs SHALL never present a conflicting or illegal pattern in any state.

Reset
REQ-024 rst SHALL force NORMAL, all lamps 100, fault 0, fault_code 00, all counters 0, flash phase lit; rst overrides every state mid-operation.
REQ-025 First cycle after rst SHALL treat the input vector as changed (hold counter 0).

Structure
REQ-026 Light code constants (GREEN 001, AMBER 010, RED 100, OFF 000), state encoding and fault_code values SHALL live in shared package traffic_pkg, also used by the phase controller.
REQ-027 A sub-module lamp_flasher (half-period counter plus phase toggle, enable input) SHALL generate the FLASH phase; remaining logic in the top module.

Verification
REQ-028 Normal 6-phase sequence from the phase controller for 3 full cycles -> lamps mirror inputs delayed 1 cycle, fault 0, mon_state 00 throughout.
REQ-029 Single-cycle in_S=001 while in_M1=001 -> SUSPECT one cycle, back to NORMAL, fault_code 00.
REQ-030 in_S=001 and in_M2=001 held 2 cycles -> FLASH, fault_code 01, lamp_M1 alternates 010/000 every 4 cycles.
REQ-031 Inputs frozen at M1=001,MT=100,M2=001,S=100 for 14 cycles -> FLASH with fault_code 11 on cycle 15.
REQ-032 In FLASH, legal inputs 8 cycles then fault_clr=1 -> ALLRED 3 cycles of 100, then NORMAL, fault_code 00; fault_clr at 5 clean cycles -> stays FLASH.
REQ-033 in_MT=011 held, rst pulsed during FLASH -> next cycle NORMAL, lamps 100, fault_code 00.
